// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU opcodes and FSM state encoding.
package alu_share_pkg;

  localparam logic [3:0] AluAnd   = 4'b0000;
  localparam logic [3:0] AluOr    = 4'b0001;
  localparam logic [3:0] AluAdd   = 4'b0010;
  localparam logic [3:0] AluXor   = 4'b0011;
  localparam logic [3:0] AluSrl   = 4'b0100;
  localparam logic [3:0] AluSra   = 4'b0101;
  localparam logic [3:0] AluSub   = 4'b0110;
  localparam logic [3:0] AluSll   = 4'b0111;
  localparam logic [3:0] AluSlt   = 4'b1000;
  localparam logic [3:0] AluSltu  = 4'b1001;
  localparam logic [3:0] AluPassb = 4'b1010;
  // Default code: the ALU returns 0 for it.
  localparam logic [3:0] AluNop   = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr+1, wrapping at N-1 to 0.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic found;

  // Two ascending passes: indices above ptr first, then the wrapped part up to ptr.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      if (!found && req[j] && (j > int'(ptr))) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IdxW'(j);
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (!found && req[j] && (j <= int'(ptr))) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant, registered
// operands, registered result returned with a valid/ready handshake tagged by requester id.
// Optional macro ALU_SHARE_ARB_B2B_EN: allow a new grant on the response handshake edge.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [4*NUM_REQ-1:0]  req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_cntrl,
  input  logic [31:0]           alu_result,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_result,
  output logic [ID_W-1:0]       resp_id
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              grant_en;
  logic              accept;
  logic [31:0]       sel_a, sel_b;
  logic [3:0]        sel_op;

  rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[4*i +: 4];
      end
    end
  end

  // Output decode: grants are only exposed while the arbiter can take a new operation.
  always_comb begin
`ifdef ALU_SHARE_ARB_B2B_EN
    grant_en = (state_q == StIdle) || ((state_q == StResp) && resp_ready);
`else
    grant_en = (state_q == StIdle);
`endif
    req_ready = grant_en ? gnt : '0;
    accept    = |req_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_ready) state_d = accept ? StExec : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operand latch on grant, result capture in EXEC, response retire on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cntrl   <= AluNop;
      resp_id     <= '0;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      resp_result <= '0;
      resp_valid  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a     <= sel_a;
        alu_b     <= sel_b;
        alu_cntrl <= sel_op;
        resp_id   <= gnt_idx;
        rr_ptr    <= gnt_idx;
      end
      if (state_q == StExec) begin
        resp_result <= alu_result;
        resp_valid  <= 1'b1;
      end else if ((state_q == StResp) && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule
